// File: rtl/id_ex_pipe_if.sv
// ID -> EX pipeline bus: ID-side handshake and payload in, EX-side handshake
// and payload out. The master drives ID_* and consumes EX_*; the slave is the
// pipeline register.
interface id_ex_pipe_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned RW  = 3,
    parameter int unsigned OPW = 4,
    parameter int unsigned IW  = 8
) ();
    // ID side
    logic           id_valid;
    logic           id_ready;
    logic [IW-1:0]  ID_instr;
    logic [OPW-1:0] ID_ALUop;
    logic           ID_regwrite;
    logic           ID_ImmLoad;
    logic [DW-1:0]  ID_regdata1;
    logic [DW-1:0]  ID_regdata2;
    logic [RW-1:0]  ID_srcreg1;
    logic [RW-1:0]  ID_srcreg2;
    logic [RW-1:0]  ID_writereg;
    logic [DW-1:0]  ID_ImmData;
    // EX side
    logic           ex_valid;
    logic           ex_ready;
    logic [IW-1:0]  EX_instr;
    logic [OPW-1:0] EX_ALUop;
    logic           EX_regwrite;
    logic           EX_ImmLoad;
    logic [DW-1:0]  EX_regdata1;
    logic [DW-1:0]  EX_regdata2;
    logic [RW-1:0]  EX_writereg;
    logic [DW-1:0]  EX_ImmData;

    modport master (
        output id_valid, ID_instr, ID_ALUop, ID_regwrite, ID_ImmLoad, ID_regdata1,
               ID_regdata2, ID_srcreg1, ID_srcreg2, ID_writereg, ID_ImmData, ex_ready,
        input  id_ready, ex_valid, EX_instr, EX_ALUop, EX_regwrite, EX_ImmLoad,
               EX_regdata1, EX_regdata2, EX_writereg, EX_ImmData
    );

    modport slave (
        input  id_valid, ID_instr, ID_ALUop, ID_regwrite, ID_ImmLoad, ID_regdata1,
               ID_regdata2, ID_srcreg1, ID_srcreg2, ID_writereg, ID_ImmData, ex_ready,
        output id_ready, ex_valid, EX_instr, EX_ALUop, EX_regwrite, EX_ImmLoad,
               EX_regdata1, EX_regdata2, EX_writereg, EX_ImmData
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register built as a 2-entry skid buffer (MAIN drives EX_*,
// SKID absorbs one extra beat under backpressure). Writeback forwarding keeps
// stored operands fresh while they wait. id_ready is registered, so there is
// no combinational path from ex_ready back to the ID stage.
module id_ex_pipe #(
    parameter int unsigned DW     = 8,
    parameter int unsigned RW     = 3,
    parameter int unsigned OPW    = 4,
    parameter int unsigned IW     = 8,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_pipe_if.slave   bus,
    input  logic          flush,
    input  logic          wb_regwrite,
    input  logic [RW-1:0] wb_writereg,
    input  logic [DW-1:0] wb_data,
    output logic [15:0]   stall_cnt
);

    typedef struct packed {
        logic [IW-1:0]  instr;
        logic [OPW-1:0] aluop;
        logic           regwrite;
        logic           immload;
        logic [DW-1:0]  regdata1;
        logic [DW-1:0]  regdata2;
        logic [RW-1:0]  srcreg1;
        logic [RW-1:0]  srcreg2;
        logic [RW-1:0]  writereg;
        logic [DW-1:0]  immdata;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e      state_q;
    entry_t      main_q;
    entry_t      skid_q;
    entry_t      id_entry;
    logic        id_ready_q;
    logic        ex_valid_q;
    logic        id_xfer;
    logic [15:0] stall_cnt_q;

    // Replace each operand whose source register is being written back this edge.
    function automatic entry_t fwd(entry_t e);
        entry_t r;
        r = e;
        if (FWD_EN && wb_regwrite) begin
            if (wb_writereg == e.srcreg1) r.regdata1 = wb_data;
            if (wb_writereg == e.srcreg2) r.regdata2 = wb_data;
        end
        return r;
    endfunction

    // Pack the incoming ID payload into an entry.
    always_comb begin
        id_entry.instr    = bus.ID_instr;
        id_entry.aluop    = bus.ID_ALUop;
        id_entry.regwrite = bus.ID_regwrite;
        id_entry.immload  = bus.ID_ImmLoad;
        id_entry.regdata1 = bus.ID_regdata1;
        id_entry.regdata2 = bus.ID_regdata2;
        id_entry.srcreg1  = bus.ID_srcreg1;
        id_entry.srcreg2  = bus.ID_srcreg2;
        id_entry.writereg = bus.ID_writereg;
        id_entry.immdata  = bus.ID_ImmData;
    end

    assign id_xfer = bus.id_valid & id_ready_q;

    // Skid-buffer FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            id_ready_q <= 1'b0;
            ex_valid_q <= 1'b0;
        end else if (flush) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            id_ready_q <= 1'b1;
            ex_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StEmpty: begin
                    id_ready_q <= 1'b1;
                    if (id_xfer) begin
                        main_q     <= fwd(id_entry);
                        state_q    <= StOne;
                        ex_valid_q <= 1'b1;
                    end
                end
                StOne: begin
                    if (id_xfer && bus.ex_ready) begin
                        main_q <= fwd(id_entry);
                    end else if (id_xfer) begin
                        main_q     <= fwd(main_q);
                        skid_q     <= fwd(id_entry);
                        state_q    <= StFull;
                        id_ready_q <= 1'b0;
                    end else if (bus.ex_ready) begin
                        // MAIN keeps its last contents for the held EX_* outputs.
                        state_q    <= StEmpty;
                        ex_valid_q <= 1'b0;
                    end else begin
                        main_q <= fwd(main_q);
                    end
                end
                StFull: begin
                    if (bus.ex_ready) begin
                        main_q     <= fwd(skid_q);
                        state_q    <= StOne;
                        id_ready_q <= 1'b1;
                    end else begin
                        main_q <= fwd(main_q);
                        skid_q <= fwd(skid_q);
                    end
                end
                default: begin
                    state_q    <= StEmpty;
                    id_ready_q <= 1'b1;
                    ex_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
        end else if (ex_valid_q && !bus.ex_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt       = stall_cnt_q;
    assign bus.id_ready    = id_ready_q;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.EX_instr    = main_q.instr;
    assign bus.EX_ALUop    = main_q.aluop;
    // Control bits are masked so a bubble never writes or loads.
    assign bus.EX_regwrite = main_q.regwrite & ex_valid_q;
    assign bus.EX_ImmLoad  = main_q.immload & ex_valid_q;
    assign bus.EX_regdata1 = main_q.regdata1;
    assign bus.EX_regdata2 = main_q.regdata2;
    assign bus.EX_writereg = main_q.writereg;
    assign bus.EX_ImmData  = main_q.immdata;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed table, hand-written forwarding/reset/saturation
// sequences and random traffic against a queue-based reference model. Two DUTs
// share stimulus, one with forwarding enabled and one without.
module tb_id_ex_pipe;
    localparam int DW  = 8;
    localparam int RW  = 3;
    localparam int OPW = 4;
    localparam int IW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush;
    logic          wb_regwrite;
    logic [RW-1:0] wb_writereg;
    logic [DW-1:0] wb_data;
    logic [15:0]   stall1;
    logic [15:0]   stall0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_if #(.DW(DW), .RW(RW), .OPW(OPW), .IW(IW)) bus1 ();
    id_ex_pipe_if #(.DW(DW), .RW(RW), .OPW(OPW), .IW(IW)) bus0 ();

    assign bus0.id_valid    = bus1.id_valid;
    assign bus0.ID_instr    = bus1.ID_instr;
    assign bus0.ID_ALUop    = bus1.ID_ALUop;
    assign bus0.ID_regwrite = bus1.ID_regwrite;
    assign bus0.ID_ImmLoad  = bus1.ID_ImmLoad;
    assign bus0.ID_regdata1 = bus1.ID_regdata1;
    assign bus0.ID_regdata2 = bus1.ID_regdata2;
    assign bus0.ID_srcreg1  = bus1.ID_srcreg1;
    assign bus0.ID_srcreg2  = bus1.ID_srcreg2;
    assign bus0.ID_writereg = bus1.ID_writereg;
    assign bus0.ID_ImmData  = bus1.ID_ImmData;
    assign bus0.ex_ready    = bus1.ex_ready;

    id_ex_pipe #(.DW(DW), .RW(RW), .OPW(OPW), .IW(IW), .FWD_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .flush(flush), .wb_regwrite(wb_regwrite),
        .wb_writereg(wb_writereg), .wb_data(wb_data), .stall_cnt(stall1)
    );

    id_ex_pipe #(.DW(DW), .RW(RW), .OPW(OPW), .IW(IW), .FWD_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .flush(flush), .wb_regwrite(wb_regwrite),
        .wb_writereg(wb_writereg), .wb_data(wb_data), .stall_cnt(stall0)
    );

    // Reference model: an in-order queue of at most two entries.
    typedef struct packed {
        logic [IW-1:0]  instr;
        logic [OPW-1:0] aluop;
        logic           regwrite;
        logic           immload;
        logic [DW-1:0]  rd1;
        logic [DW-1:0]  rd2;
        logic [RW-1:0]  s1;
        logic [RW-1:0]  s2;
        logic [RW-1:0]  wr;
        logic [DW-1:0]  imm;
    } ent_t;

    ent_t q1[$];
    ent_t q0[$];
    ent_t shown1;
    ent_t shown0;
    bit   m_idr;
    int   m_stall;

    typedef struct {
        bit         v;
        logic [7:0] instr;
        bit         rdy;
        bit         fl;
        bit         e_ev;
        logic [7:0] e_instr;
        bit         e_idr;
        int         e_stall;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t cur_in();
        ent_t e;
        e.instr    = bus1.ID_instr;
        e.aluop    = bus1.ID_ALUop;
        e.regwrite = bus1.ID_regwrite;
        e.immload  = bus1.ID_ImmLoad;
        e.rd1      = bus1.ID_regdata1;
        e.rd2      = bus1.ID_regdata2;
        e.s1       = bus1.ID_srcreg1;
        e.s2       = bus1.ID_srcreg2;
        e.wr       = bus1.ID_writereg;
        e.imm      = bus1.ID_ImmData;
        return e;
    endfunction

    function automatic ent_t apply_wb(ent_t e);
        ent_t r;
        r = e;
        if (wb_regwrite) begin
            if (wb_writereg == e.s1) r.rd1 = wb_data;
            if (wb_writereg == e.s2) r.rd2 = wb_data;
        end
        return r;
    endfunction

    task automatic model_reset();
        q1.delete();
        q0.delete();
        shown1  = '0;
        shown0  = '0;
        m_idr   = 1'b0;
        m_stall = 0;
    endtask

    task automatic check_all();
        bit ev;
        ev = (q1.size() > 0);
        chk("ex_valid",    32'(bus1.ex_valid),    32'(ev));
        chk("id_ready",    32'(bus1.id_ready),    32'(m_idr));
        chk("EX_instr",    32'(bus1.EX_instr),    32'(shown1.instr));
        chk("EX_ALUop",    32'(bus1.EX_ALUop),    32'(shown1.aluop));
        chk("EX_regwrite", 32'(bus1.EX_regwrite), 32'(shown1.regwrite & ev));
        chk("EX_ImmLoad",  32'(bus1.EX_ImmLoad),  32'(shown1.immload & ev));
        chk("EX_regdata1", 32'(bus1.EX_regdata1), 32'(shown1.rd1));
        chk("EX_regdata2", 32'(bus1.EX_regdata2), 32'(shown1.rd2));
        chk("EX_writereg", 32'(bus1.EX_writereg), 32'(shown1.wr));
        chk("EX_ImmData",  32'(bus1.EX_ImmData),  32'(shown1.imm));
        chk("stall_cnt",   32'(stall1),           32'(m_stall));
        chk("nofwd_ex_valid", 32'(bus0.ex_valid),    32'(ev));
        chk("nofwd_instr",    32'(bus0.EX_instr),    32'(shown0.instr));
        chk("nofwd_regdata1", 32'(bus0.EX_regdata1), 32'(shown0.rd1));
        chk("nofwd_regdata2", 32'(bus0.EX_regdata2), 32'(shown0.rd2));
        chk("nofwd_stall",    32'(stall0),           32'(m_stall));
    endtask

    // Advance the model from the current inputs, take one clock edge, compare.
    task automatic cycle();
        bit   acc;
        bit   pop;
        ent_t in_e;
        acc  = bus1.id_valid && m_idr;
        pop  = bus1.ex_ready && (q1.size() > 0);
        in_e = cur_in();
        if ((q1.size() > 0) && !bus1.ex_ready && (m_stall < 65535)) m_stall++;
        if (flush) begin
            q1.delete();
            q0.delete();
            shown1 = '0;
            shown0 = '0;
            m_idr  = 1'b1;
        end else begin
            for (int i = 0; i < q1.size(); i++) q1[i] = apply_wb(q1[i]);
            if (pop) begin
                void'(q1.pop_front());
                void'(q0.pop_front());
            end
            if (acc) begin
                q1.push_back(apply_wb(in_e));
                q0.push_back(in_e);
            end
            if (q1.size() > 0) begin
                shown1 = q1[0];
                shown0 = q0[0];
            end
            m_idr = (q1.size() < 2);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_in(input bit v, input logic [7:0] instr, input logic [2:0] s1,
                          input logic [2:0] s2, input logic [7:0] d1, input logic [7:0] d2);
        bus1.id_valid    = v;
        bus1.ID_instr    = instr;
        bus1.ID_srcreg1  = s1;
        bus1.ID_srcreg2  = s2;
        bus1.ID_regdata1 = d1;
        bus1.ID_regdata2 = d2;
    endtask

    task automatic set_wb(input bit we, input logic [2:0] r, input logic [7:0] d);
        wb_regwrite = we;
        wb_writereg = r;
        wb_data     = d;
    endtask

    initial begin
        bus1.id_valid    = 1'b0;
        bus1.ID_instr    = '0;
        bus1.ID_ALUop    = '0;
        bus1.ID_regwrite = 1'b0;
        bus1.ID_ImmLoad  = 1'b0;
        bus1.ID_regdata1 = '0;
        bus1.ID_regdata2 = '0;
        bus1.ID_srcreg1  = '0;
        bus1.ID_srcreg2  = '0;
        bus1.ID_writereg = '0;
        bus1.ID_ImmData  = '0;
        bus1.ex_ready    = 1'b0;
        flush            = 1'b0;
        set_wb(1'b0, 3'd0, 8'h00);
        model_reset();

        // Reset state
        #12;
        chk("rst_ex_valid", 32'(bus1.ex_valid), 32'd0);
        chk("rst_id_ready", 32'(bus1.id_ready), 32'd0);
        chk("rst_stall",    32'(stall1),        32'd0);
        chk("rst_instr",    32'(bus1.EX_instr), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_rel_id_ready_before_edge", 32'(bus1.id_ready), 32'd0);
        cycle();

        // Directed table: streaming, backpressure, flush
        //             v  instr   rdy fl   ev  instr  idr stall
        tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 0};
        tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 0};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 0};
        tbl[4]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 0};
        tbl[5]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1};
        tbl[6]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 2};
        tbl[7]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 2};
        tbl[8]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 2};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA3, 1'b1, 2};
        tbl[10] = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b1, 2};
        tbl[11] = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 3};
        tbl[12] = '{1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 4};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4};
        bus1.ID_regwrite = 1'b1;
        foreach (tbl[i]) begin
            bus1.id_valid = tbl[i].v;
            bus1.ID_instr = tbl[i].instr;
            bus1.ex_ready = tbl[i].rdy;
            flush         = tbl[i].fl;
            cycle();
            chk($sformatf("tbl%0d_ex_valid", i), 32'(bus1.ex_valid),    32'(tbl[i].e_ev));
            chk($sformatf("tbl%0d_instr", i),    32'(bus1.EX_instr),    32'(tbl[i].e_instr));
            chk($sformatf("tbl%0d_id_ready", i), 32'(bus1.id_ready),    32'(tbl[i].e_idr));
            chk($sformatf("tbl%0d_regwrite", i), 32'(bus1.EX_regwrite), 32'(tbl[i].e_ev));
            chk($sformatf("tbl%0d_stall", i),    32'(stall1),           32'(tbl[i].e_stall));
        end
        flush = 1'b0;

        // Forwarding into a stalled stored entry
        bus1.ex_ready = 1'b0;
        set_in(1'b1, 8'hC1, 3'd3, 3'd5, 8'h05, 8'h09);
        cycle();
        set_in(1'b0, 8'h00, 3'd0, 3'd0, 8'h00, 8'h00);
        set_wb(1'b1, 3'd3, 8'h7E);
        cycle();
        chk("fwd_on_rd1",  32'(bus1.EX_regdata1), 32'h7E);
        chk("fwd_on_rd2",  32'(bus1.EX_regdata2), 32'h09);
        chk("fwd_off_rd1", 32'(bus0.EX_regdata1), 32'h05);
        set_wb(1'b0, 3'd0, 8'h00);
        bus1.ex_ready = 1'b1;
        cycle();

        // Capture-time forwarding with srcreg1 == srcreg2
        bus1.ex_ready = 1'b0;
        set_in(1'b1, 8'hC2, 3'd4, 3'd4, 8'h01, 8'h02);
        set_wb(1'b1, 3'd4, 8'h5A);
        cycle();
        chk("fwd_cap_rd1",     32'(bus1.EX_regdata1), 32'h5A);
        chk("fwd_cap_rd2",     32'(bus1.EX_regdata2), 32'h5A);
        chk("fwd_cap_off_rd2", 32'(bus0.EX_regdata2), 32'h02);
        // Capture into SKID, then forward again as it moves to MAIN
        set_in(1'b1, 8'hC3, 3'd6, 3'd1, 8'h11, 8'h22);
        set_wb(1'b1, 3'd1, 8'h33);
        cycle();
        set_in(1'b0, 8'h00, 3'd0, 3'd0, 8'h00, 8'h00);
        set_wb(1'b1, 3'd6, 8'h44);
        bus1.ex_ready = 1'b1;
        cycle();
        chk("fwd_move_instr", 32'(bus1.EX_instr),    32'hC3);
        chk("fwd_move_rd1",   32'(bus1.EX_regdata1), 32'h44);
        chk("fwd_move_rd2",   32'(bus1.EX_regdata2), 32'h33);
        set_wb(1'b0, 3'd0, 8'h00);
        cycle();

        // Random traffic, with an asynchronous reset in the middle of it
        for (int i = 0; i < 3000; i++) begin
            bus1.id_valid    = ($urandom_range(0, 3) != 0);
            bus1.ID_instr    = 8'($urandom);
            bus1.ID_ALUop    = 4'($urandom);
            bus1.ID_regwrite = 1'($urandom);
            bus1.ID_ImmLoad  = 1'($urandom);
            bus1.ID_regdata1 = 8'($urandom);
            bus1.ID_regdata2 = 8'($urandom);
            bus1.ID_srcreg1  = 3'($urandom);
            bus1.ID_srcreg2  = 3'($urandom);
            bus1.ID_writereg = 3'($urandom);
            bus1.ID_ImmData  = 8'($urandom);
            bus1.ex_ready    = ($urandom_range(0, 2) != 0);
            flush            = ($urandom_range(0, 39) == 0);
            set_wb(1'($urandom), 3'($urandom), 8'($urandom));
            cycle();
            if (i == 1500) begin
                #1;
                rst = 1'b0;
                #1;
                chk("midrst_ex_valid", 32'(bus1.ex_valid),    32'd0);
                chk("midrst_id_ready", 32'(bus1.id_ready),    32'd0);
                chk("midrst_stall",    32'(stall1),           32'd0);
                chk("midrst_instr",    32'(bus1.EX_instr),    32'd0);
                chk("midrst_rd1",      32'(bus1.EX_regdata1), 32'd0);
                chk("midrst_regwrite", 32'(bus1.EX_regwrite), 32'd0);
                model_reset();
                #1;
                rst = 1'b1;
            end
        end

        // Saturation of the stall counter
        flush = 1'b0;
        set_wb(1'b0, 3'd0, 8'h00);
        bus1.ex_ready = 1'b0;
        bus1.id_valid = 1'b1;
        cycle();
        bus1.id_valid = 1'b0;
        for (int i = 0; i < 65540; i++) cycle();
        chk("stall_sat",       32'(stall1), 32'hFFFF);
        chk("stall_sat_nofwd", 32'(stall0), 32'hFFFF);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("stall_after_flush", 32'(stall1), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter DW, default 8: register-data and immediate width.
REQ-002 Parameter RW, default 3: register-address width.
REQ-003 Parameter OPW, default 4: ALU opcode width; IW, default 8: instruction width.
REQ-004 Parameter FWD_EN, default 1: enables writeback forwarding into stored/captured operands.
REQ-005 Port clk  in  1  single clock, all state on rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-low.
REQ-007 Ports id_valid in 1 / id_ready out 1: ID-side handshake; transfer when both high at clk edge.
REQ-008 Ports ID_instr IW, ID_ALUop OPW, ID_regwrite 1, ID_ImmLoad 1, ID_regdata1/ID_regdata2 DW, ID_srcreg1/ID_srcreg2 RW, ID_writereg RW, ID_ImmData DW, all in: ID payload.
REQ-009 Ports ex_valid out 1 / ex_ready in 1: EX-side handshake.
REQ-010 Ports EX_instr, EX_ALUop, EX_regwrite, EX_ImmLoad, EX_regdata1, EX_regdata2, EX_writereg, EX_ImmData, out, widths as ID counterparts.
REQ-011 Port flush in 1: synchronous pipeline flush (branch/exception).
REQ-012 Ports wb_regwrite in 1, wb_writereg in RW, wb_data in DW: writeback bus for forwarding.
REQ-013 Port stall_cnt out 16: count of cycles with ex_valid=1 and ex_ready=0.

Function
REQ-014 Storage SHALL be a 2-entry skid buffer: MAIN (drives EX_*) and SKID.
REQ-015 States SHALL be EMPTY (no valid entry), ONE (MAIN valid), FULL (MAIN+SKID valid).
REQ-016 id_ready SHALL be registered, equal 1 in EMPTY/ONE, 0 in FULL; no combinational path ex_ready->id_ready.
REQ-017 ex_valid SHALL be 1 in ONE/FULL, 0 in EMPTY.
REQ-018 EMPTY: ID transfer -> ONE, payload into MAIN; else stay.
REQ-019 ONE: transfer and ex_ready -> ONE, MAIN replaced; transfer and !ex_ready -> FULL, payload into SKID; no transfer and ex_ready -> EMPTY; else hold.
REQ-020 FULL: ex_ready -> ONE, MAIN <= SKID; else hold; no ID transfer possible.
REQ-021 Latency SHALL be 1 cycle: payload accepted at edge N appears on EX_* after edge N when stage was EMPTY, or ONE with ex_ready=1.
REQ-022 Entries SHALL leave in acceptance order; no loss, no duplication.
REQ-023 EX_regwrite and EX_ImmLoad SHALL read 0 whenever ex_valid=0; other EX_* hold last value.
REQ-024 flush=1 at an edge SHALL force EMPTY, clear both entries to 0, discard any same-cycle ID transfer, set id_ready=1; flush overrides all handshakes.
REQ-025 FWD_EN=1: for each valid stored entry, if wb_regwrite=1 and wb_writereg equals its srcreg1 (srcreg2), regdata1 (regdata2) SHALL be replaced by wb_data at that edge.
REQ-026 FWD_EN=1: payload captured (into MAIN or SKID) or moved SKID->MAIN at an edge with matching writeback SHALL store wb_data instead of the stale operand.
REQ-027 Both operands SHALL be forwarded independently; srcreg1=srcreg2 match updates both.
REQ-028 FWD_EN=0: operands SHALL be stored unmodified.
REQ-029 stall_cnt SHALL increment by 1 each cycle with ex_valid=1, ex_ready=0, saturate at 16'hFFFF, unaffected by flush.

Reset
REQ-030 rst=0 SHALL immediately force EMPTY, all entries and EX_* to 0, ex_valid=0, id_ready=0, stall_cnt=0.
REQ-031 id_ready SHALL rise to 1 at the first clk edge after rst deasserts; reset mid-transfer SHALL drop all in-flight entries.

Verification
REQ-032 Reset: rst=0 mid-stream -> EX_* =0, ex_valid=0, stall_cnt=0 without clock edge.
REQ-033 Streaming: ex_ready=1, ID_instr 0x11,0x22,0x33 back-to-back -> EX_instr 0x11,0x22,0x33 on consecutive cycles, id_ready stays 1.
REQ-034 Backpressure: ex_ready=0, send 0xA1,0xA2 -> FULL, id_ready=0, 0xA3 held upstream; ex_ready=1 -> outputs 0xA1,0xA2,0xA3 in order, stall_cnt equals stalled cycles.
REQ-035 Flush: FULL with 0xB1,0xB2, flush=1 with id_valid=1 (0xB3) -> next cycle ex_valid=0, EX_regwrite=0, 0xB3 never emitted.
REQ-036 Forwarding: stored entry srcreg1=3, regdata1=0x05, stalled; wb_regwrite=1, wb_writereg=3, wb_data=0x7E -> EX_regdata1=0x7E next cycle; same with FWD_EN=0 -> stays 0x05.
REQ-037 Saturation: hold ex_valid=1, ex_ready=0 for 65540 cycles -> stall_cnt=0xFFFF.
